// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, addresses the synchronous instruction memory and pairs each
// returned word with its PC for decode, absorbing back-pressure and execute redirects.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_misalign,
    output logic [31:0] fetch_count
);

    localparam logic [1:0] BOOT = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] count_q, count_d;
    logic        misalign_q, misalign_d;
    logic [31:0] fetch_pc;
    logic        valid;
    logic [31:0] pc_next;

    assign pc_next = pc_q + 32'd4;

    // fetch_pc is the byte address whose word the memory returns next cycle; pc_d tracks it.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        count_d    = count_q;
        misalign_d = misalign_q;
        fetch_pc   = pc_q;
        valid      = 1'b0;
        case (state_q)
            BOOT: begin
                fetch_pc = RESET_PC;
                state_d  = RUN;
            end
            RUN: begin
                valid = ~redirect_valid;
                if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
                    state_d    = HALT;
                    misalign_d = 1'b1;
                end else if (redirect_valid) begin
                    fetch_pc = redirect_pc;
                    pc_d     = redirect_pc;
                end else if (out_ready) begin
                    fetch_pc = pc_next;
                    pc_d     = pc_next;
                    count_d  = count_q + 32'd1;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
        if (!rst) begin
            fetch_pc = RESET_PC;
            valid    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            count_q    <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_addr      = {2'b00, fetch_pc[31:2]};
    assign out_valid      = valid;
    assign out_pc         = pc_q;
    assign out_inst       = valid ? imem_inst : NOP_INST;
    assign fetch_misalign = misalign_q;
    assign fetch_count    = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a default-PC instance plus a wrap-around instance
// sharing stimulus, each fed by an address-derived memory model.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        out_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;

    logic [31:0] imem_addr, imem_inst, out_pc, out_inst, fetch_count;
    logic        out_valid, fetch_misalign;
    logic [31:0] w_imem_addr, w_imem_inst, w_out_pc, w_out_inst, w_fetch_count;
    logic        w_out_valid, w_fetch_misalign;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_count;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_inst(imem_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_misalign(fetch_misalign), .fetch_count(fetch_count)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .imem_addr(w_imem_addr), .imem_inst(w_imem_inst),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_pc(w_out_pc), .out_inst(w_out_inst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_misalign(w_fetch_misalign), .fetch_count(w_fetch_count)
    );

    // Memory contents are a fixed function of the word index, so any address is "preloaded".
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[15:0]};
    endfunction

    always @(posedge clk) begin
        imem_inst   <= word_of(imem_addr);
        w_imem_inst <= word_of(w_imem_addr);
    end

    task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    task automatic test_reset;
        drive(1'b1, 1'b1, 32'h40);
        drive(1'b1, 1'b1, 32'h40);
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid got=%b want=0", out_valid); end
        total++; if (out_inst !== 32'h13) begin bad++; $display("[TB] FAIL rst_inst got=%h want=00000013", out_inst); end
        total++; if (imem_addr !== 32'd0) begin bad++; $display("[TB] FAIL rst_addr got=%h want=0", imem_addr); end
        total++; if (out_pc !== 32'd0) begin bad++; $display("[TB] FAIL rst_pc got=%h want=0", out_pc); end
        total++; if (fetch_count !== 32'd0) begin bad++; $display("[TB] FAIL rst_count got=%0d want=0", fetch_count); end
        total++; if (fetch_misalign !== 1'b0) begin bad++; $display("[TB] FAIL rst_misalign got=%b want=0", fetch_misalign); end
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL boot_valid got=%b want=0", out_valid); end
        total++; if (imem_addr !== 32'd0) begin bad++; $display("[TB] FAIL boot_addr got=%h want=0", imem_addr); end
        exp_count = 32'd0;
    endtask

    task automatic test_sequential;
        for (int i = 0; i < 16; i++) exp_q.push_back(32'(i * 4));
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 32'd0);
            exp_pc = exp_q.pop_front();
            total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL seq_valid i=%0d got=%b want=1", i, out_valid); end
            total++; if (out_pc !== exp_pc) begin bad++; $display("[TB] FAIL seq_pc got=%h want=%h", out_pc, exp_pc); end
            total++; if (out_inst !== word_of(exp_pc >> 2)) begin bad++; $display("[TB] FAIL seq_inst got=%h want=%h", out_inst, word_of(exp_pc >> 2)); end
            total++; if (imem_addr !== ((exp_pc + 32'd4) >> 2)) begin bad++; $display("[TB] FAIL seq_addr got=%h want=%h", imem_addr, (exp_pc + 32'd4) >> 2); end
            total++; if (fetch_count !== exp_count) begin bad++; $display("[TB] FAIL seq_count got=%0d want=%0d", fetch_count, exp_count); end
            exp_count++;
        end
        drive(1'b0, 1'b0, 32'd0);
        total++; if (fetch_count !== 32'd16) begin bad++; $display("[TB] FAIL seq_count16 got=%0d want=16", fetch_count); end
        total++; if (out_pc !== 32'h40) begin bad++; $display("[TB] FAIL seq_endpc got=%h want=40", out_pc); end
    endtask

    task automatic test_stall;
        drive(1'b0, 1'b1, 32'h8);
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL stall_redir_valid got=%b want=0", out_valid); end
        total++; if (imem_addr !== 32'd2) begin bad++; $display("[TB] FAIL stall_redir_addr got=%h want=2", imem_addr); end
        exp_q.push_back(32'h8);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 32'd0);
            total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL stall_valid k=%0d got=%b want=1", k, out_valid); end
            total++; if (out_pc !== 32'h8) begin bad++; $display("[TB] FAIL stall_pc got=%h want=8", out_pc); end
            total++; if (out_inst !== word_of(32'd2)) begin bad++; $display("[TB] FAIL stall_inst got=%h want=%h", out_inst, word_of(32'd2)); end
            total++; if (imem_addr !== 32'd2) begin bad++; $display("[TB] FAIL stall_addr got=%h want=2", imem_addr); end
            total++; if (fetch_count !== exp_count) begin bad++; $display("[TB] FAIL stall_count got=%0d want=%0d", fetch_count, exp_count); end
        end
        drive(1'b1, 1'b0, 32'd0);
        exp_pc = exp_q.pop_front();
        total++; if (out_pc !== exp_pc) begin bad++; $display("[TB] FAIL stall_xfer_pc got=%h want=%h", out_pc, exp_pc); end
        total++; if (out_inst !== word_of(exp_pc >> 2)) begin bad++; $display("[TB] FAIL stall_xfer_inst got=%h want=%h", out_inst, word_of(exp_pc >> 2)); end
        exp_count++;
    endtask

    task automatic test_redirect;
        exp_q.push_back(32'hC);
        drive(1'b1, 1'b0, 32'd0);
        exp_pc = exp_q.pop_front();
        total++; if (out_pc !== exp_pc) begin bad++; $display("[TB] FAIL redir_pre_pc got=%h want=%h", out_pc, exp_pc); end
        exp_count++;
        drive(1'b1, 1'b1, 32'h40);
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL redir_valid got=%b want=0", out_valid); end
        total++; if (out_inst !== 32'h13) begin bad++; $display("[TB] FAIL redir_nop got=%h want=00000013", out_inst); end
        total++; if (imem_addr !== 32'h10) begin bad++; $display("[TB] FAIL redir_addr got=%h want=10", imem_addr); end
        total++; if (out_pc !== 32'h10) begin bad++; $display("[TB] FAIL redir_inflight_pc got=%h want=10", out_pc); end
        exp_q.push_back(32'h40);
        drive(1'b1, 1'b0, 32'd0);
        exp_pc = exp_q.pop_front();
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL redir_tgt_valid got=%b want=1", out_valid); end
        total++; if (out_pc !== exp_pc) begin bad++; $display("[TB] FAIL redir_tgt_pc got=%h want=%h", out_pc, exp_pc); end
        total++; if (out_inst !== word_of(32'd16)) begin bad++; $display("[TB] FAIL redir_tgt_inst got=%h want=%h", out_inst, word_of(32'd16)); end
        exp_count++;
        drive(1'b0, 1'b0, 32'd0);
        total++; if (fetch_count !== exp_count) begin bad++; $display("[TB] FAIL redir_count got=%0d want=%0d", fetch_count, exp_count); end
        total++; if (out_pc !== 32'h44) begin bad++; $display("[TB] FAIL redir_next_pc got=%h want=44", out_pc); end
    endtask

    task automatic test_redirect_stall;
        drive(1'b0, 1'b1, 32'h20);
        drive(1'b0, 1'b0, 32'd0);
        total++; if (out_pc !== 32'h20) begin bad++; $display("[TB] FAIL rstall_pc got=%h want=20", out_pc); end
        drive(1'b0, 1'b1, 32'h4);
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rstall_valid got=%b want=0", out_valid); end
        exp_q.push_back(32'h4);
        drive(1'b1, 1'b0, 32'd0);
        exp_pc = exp_q.pop_front();
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL rstall_tgt_valid got=%b want=1", out_valid); end
        total++; if (out_pc !== exp_pc) begin bad++; $display("[TB] FAIL rstall_tgt_pc got=%h want=%h", out_pc, exp_pc); end
        total++; if (out_inst !== word_of(32'd1)) begin bad++; $display("[TB] FAIL rstall_tgt_inst got=%h want=%h", out_inst, word_of(32'd1)); end
        exp_count++;
    endtask

    task automatic test_misalign;
        drive(1'b1, 1'b1, 32'h42);
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL mis_valid got=%b want=0", out_valid); end
        total++; if (fetch_misalign !== 1'b0) begin bad++; $display("[TB] FAIL mis_early got=%b want=0", fetch_misalign); end
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, (k == 2), 32'h40);
            total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL halt_valid k=%0d got=%b want=0", k, out_valid); end
            total++; if (fetch_misalign !== 1'b1) begin bad++; $display("[TB] FAIL halt_flag got=%b want=1", fetch_misalign); end
            total++; if (fetch_count !== exp_count) begin bad++; $display("[TB] FAIL halt_count got=%0d want=%0d", fetch_count, exp_count); end
            total++; if (imem_addr !== 32'd2) begin bad++; $display("[TB] FAIL halt_addr got=%h want=2", imem_addr); end
            total++; if (out_inst !== 32'h13) begin bad++; $display("[TB] FAIL halt_nop got=%h want=00000013", out_inst); end
        end
        rst = 1'b0;
        #1;
        total++; if (imem_addr !== 32'd0) begin bad++; $display("[TB] FAIL mrst_addr got=%h want=0", imem_addr); end
        drive(1'b0, 1'b0, 32'd0);
        total++; if (fetch_misalign !== 1'b0) begin bad++; $display("[TB] FAIL mrst_flag got=%b want=0", fetch_misalign); end
        total++; if (fetch_count !== 32'd0) begin bad++; $display("[TB] FAIL mrst_count got=%0d want=0", fetch_count); end
        rst = 1'b1;
        exp_count = 32'd0;
        exp_q.delete();
        exp_q.push_back(32'd0);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL mrst_boot_valid got=%b want=0", out_valid); end
        drive(1'b0, 1'b0, 32'd0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL mrst_run_valid got=%b want=1", out_valid); end
        total++; if (out_pc !== 32'd0) begin bad++; $display("[TB] FAIL mrst_run_pc got=%h want=0", out_pc); end
    endtask

    task automatic test_wrap;
        total++; if (w_out_valid !== 1'b1) begin bad++; $display("[TB] FAIL wrap_valid got=%b want=1", w_out_valid); end
        total++; if (w_out_pc !== 32'hFFFF_FFFC) begin bad++; $display("[TB] FAIL wrap_pc0 got=%h want=fffffffc", w_out_pc); end
        total++; if (w_imem_addr !== 32'h3FFF_FFFF) begin bad++; $display("[TB] FAIL wrap_addr0 got=%h want=3fffffff", w_imem_addr); end
        total++; if (w_out_inst !== word_of(32'h3FFF_FFFF)) begin bad++; $display("[TB] FAIL wrap_inst0 got=%h want=%h", w_out_inst, word_of(32'h3FFF_FFFF)); end
        drive(1'b1, 1'b0, 32'd0);
        total++; if (w_imem_addr !== 32'd0) begin bad++; $display("[TB] FAIL wrap_addr1 got=%h want=0", w_imem_addr); end
        exp_pc = exp_q.pop_front();
        total++; if (out_pc !== exp_pc) begin bad++; $display("[TB] FAIL wrap_main_pc got=%h want=%h", out_pc, exp_pc); end
        exp_count++;
        drive(1'b0, 1'b0, 32'd0);
        total++; if (w_out_pc !== 32'd0) begin bad++; $display("[TB] FAIL wrap_pc1 got=%h want=0", w_out_pc); end
        total++; if (w_out_inst !== word_of(32'd0)) begin bad++; $display("[TB] FAIL wrap_inst1 got=%h want=%h", w_out_inst, word_of(32'd0)); end
        total++; if (w_fetch_count !== 32'd1) begin bad++; $display("[TB] FAIL wrap_count got=%0d want=1", w_fetch_count); end
        total++; if (fetch_count !== exp_count) begin bad++; $display("[TB] FAIL wrap_main_count got=%0d want=%0d", fetch_count, exp_count); end
        total++; if (out_pc !== 32'h4) begin bad++; $display("[TB] FAIL wrap_main_pc1 got=%h want=4", out_pc); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_misalign();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
